// File: rtl/mem_pkg.sv
// Shared types and width helpers for the arbitrated single-port RAM.
package mem_pkg;

  // Wide enough for up to eight requester channels.
  localparam int CH_W = 3;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic            rd;
    logic            err;
  } pipe_stage_t;

  function automatic int strb_w(input int buswidth);
    return buswidth / 8;
  endfunction

  function automatic int off_w(input int buswidth);
    return (buswidth / 8 > 1) ? $clog2(buswidth / 8) : 0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_found;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    gnt        = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    // First pass covers pointer..top, second pass wraps to 0..pointer-1.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_found && req[c] && c >= int'(r_ptr)) begin
        gnt[c]     = 1'b1;
        w_found    = 1'b1;
        w_next_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_found && req[c] && c < int'(r_ptr)) begin
        gnt[c]     = 1'b1;
        w_found    = 1'b1;
        w_next_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/mem_arb_ram.sv
// Multi-channel round-robin arbitrated RAM with byte strobes and fixed read latency.
// Optional MEM_OOR_ERR_EN adds rsp_err and suppresses out-of-range accesses.
module mem_arb_ram
  import mem_pkg::*;
#(
  parameter int BUSWIDTH   = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int DEPTH      = 1024,
  parameter int NUM_CH     = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               req_valid,
  output logic [NUM_CH-1:0]               req_ready,
  input  logic [NUM_CH*ADDRWIDTH-1:0]     req_addr,
  input  logic [NUM_CH-1:0]               req_wren,
  input  logic [NUM_CH*BUSWIDTH-1:0]      req_wdata,
  input  logic [NUM_CH*(BUSWIDTH/8)-1:0]  req_strb,
  output logic [NUM_CH-1:0]               rsp_valid,
  output logic [BUSWIDTH-1:0]             rsp_rdata
`ifdef MEM_OOR_ERR_EN
  ,
  output logic                            rsp_err
`endif
);

  localparam int STRB_W = strb_w(BUSWIDTH);
  localparam int OFF_W  = off_w(BUSWIDTH);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [BUSWIDTH-1:0]  r_mem [DEPTH];
  logic [NUM_CH-1:0]    w_req;
  logic [NUM_CH-1:0]    w_gnt;
  logic                 w_accept;
  logic [CH_W-1:0]      w_sel_ch;
  logic [ADDRWIDTH-1:0] w_sel_addr;
  logic                 w_sel_wren;
  logic [BUSWIDTH-1:0]  w_sel_wdata;
  logic [STRB_W-1:0]    w_sel_strb;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_oor;
  logic                 w_unused_addr;
  pipe_stage_t          r_st1;
  pipe_stage_t          w_st_out;
  logic [BUSWIDTH-1:0]  r_data1;
  logic [BUSWIDTH-1:0]  w_data_out;

  // Gating requests with rst_n keeps req_ready low and blocks writes during reset.
  assign w_req = req_valid & {NUM_CH{rst_n}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;

  always_comb begin
    w_sel_ch    = '0;
    w_sel_addr  = '0;
    w_sel_wren  = 1'b0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_gnt[c]) begin
        w_sel_ch    = CH_W'(c);
        w_sel_addr  = req_addr[c*ADDRWIDTH +: ADDRWIDTH];
        w_sel_wren  = req_wren[c];
        w_sel_wdata = req_wdata[c*BUSWIDTH +: BUSWIDTH];
        w_sel_strb  = req_strb[c*STRB_W +: STRB_W];
      end
    end
  end

  assign w_idx         = w_sel_addr[OFF_W +: IDX_W];
  assign w_unused_addr = ^w_sel_addr;

`ifdef MEM_OOR_ERR_EN
  assign w_oor = (w_sel_addr >> (OFF_W + IDX_W)) != '0;
`else
  assign w_oor = 1'b0;
`endif

  // NOTE: the memory array and its read register carry no reset; outputs are qualified by the reset pipeline.
  always_ff @(posedge clk) begin
    if (w_accept && w_sel_wren && !w_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_sel_strb[b]) r_mem[w_idx][b*8 +: 8] <= w_sel_wdata[b*8 +: 8];
      end
    end
  end

  // A write committed at the previous edge is already visible here, so no bypass is needed.
  always_ff @(posedge clk) begin
    r_data1 <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st1 <= '0;
    end else begin
      r_st1.valid <= w_accept;
      r_st1.ch    <= w_sel_ch;
      r_st1.rd    <= !w_sel_wren;
      r_st1.err   <= w_oor;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      pipe_stage_t         r_st2;
      logic [BUSWIDTH-1:0] r_data2;
      always_ff @(posedge clk) begin
        if (!rst_n) r_st2 <= '0;
        else        r_st2 <= r_st1;
        r_data2 <= r_data1;
      end
      assign w_st_out   = r_st2;
      assign w_data_out = r_data2;
    end else begin : g_lat1
      assign w_st_out   = r_st1;
      assign w_data_out = r_data1;
    end
  endgenerate

  always_comb begin
    rsp_valid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_st_out.valid && w_st_out.ch == CH_W'(c)) rsp_valid[c] = 1'b1;
    end
    rsp_rdata = (w_st_out.valid && w_st_out.rd && !w_st_out.err) ? w_data_out : '0;
  end

`ifdef MEM_OOR_ERR_EN
  assign rsp_err = w_st_out.valid && w_st_out.err;
`endif

endmodule

// File: tb/tb_mem_arb_ram.sv
// Directed self-checking bench for mem_arb_ram at default parameters.
module tb_mem_arb_ram;

  localparam int BW  = 32;
  localparam int AW  = 32;
  localparam int NCH = 2;
  localparam int LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_ready;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH-1:0]    req_wren = '0;
  logic [NCH*BW-1:0] req_wdata = '0;
  logic [NCH*4-1:0]  req_strb = '0;
  logic [NCH-1:0]    rsp_valid;
  logic [BW-1:0]     rsp_rdata;
`ifdef MEM_OOR_ERR_EN
  logic              rsp_err;
  logic              last_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb_ram #(
    .BUSWIDTH(BW), .ADDRWIDTH(AW), .DEPTH(1024), .NUM_CH(NCH), .RD_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wren  (req_wren),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
`ifdef MEM_OOR_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic wren, input logic [AW-1:0] addr,
                       input logic [BW-1:0] wdata, input logic [3:0] strb);
    req_valid[ch]           = 1'b1;
    req_wren[ch]            = wren;
    req_addr[ch*AW +: AW]   = addr;
    req_wdata[ch*BW +: BW]  = wdata;
    req_strb[ch*4 +: 4]     = strb;
  endtask

  // Single-channel transaction: captures ready before the edge and the response LAT edges later.
  task automatic xfer(input int ch, input logic wren, input logic [AW-1:0] addr,
                      input logic [BW-1:0] wdata, input logic [3:0] strb,
                      output logic rdy, output logic [NCH-1:0] vld, output logic [BW-1:0] data);
    req_valid = '0;
    drive(ch, wren, addr, wdata, strb);
    #1;
    rdy = req_ready[ch];
    step();
    req_valid = '0;
    repeat (LAT - 1) step();
    vld  = rsp_valid;
    data = rsp_rdata;
`ifdef MEM_OOR_ERR_EN
    last_err = rsp_err;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h4, 32'h0, 4'h0);
    step();
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rsp_rdata); end
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b exp 00", req_ready); end
    step();
  endtask

  task automatic test_write_read();
    logic rdy; logic [NCH-1:0] vld; logic [BW-1:0] data;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdy, vld, data);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b exp 1", rdy); end
    checks++; if ({vld, data} !== {2'b01, 32'h0}) begin errors++; $display("FAIL wr_ack: got %b/%h exp 01/00000000", vld, data); end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rdy, vld, data);
    checks++; if ({vld, data} !== {2'b01, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_10: got %b/%h exp 01/deadbeef", vld, data); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rsp_pulse: got %b/%h exp 00/00000000", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_strobe();
    logic rdy; logic [NCH-1:0] vld; logic [BW-1:0] data;
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rdy, vld, data);
    xfer(0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'h2, rdy, vld, data);
    xfer(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rdy, vld, data);
    xfer(1, 1'b0, 32'h23, 32'h0, 4'h0, rdy, vld, data);
    checks++; if ({vld, data} !== {2'b10, 32'h1122AA44}) begin errors++; $display("FAIL strobe_rd: got %b/%h exp 10/1122aa44", vld, data); end
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [BW-1:0]  exp_dat [4] = '{32'hDEADBEEF, 32'h1122AA44, 32'hDEADBEEF, 32'h1122AA44};
    rst_n = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_ready !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt%0d: got %b exp %b", k, req_ready, exp_gnt[k]); end
      step();
      checks++; if ({rsp_valid, rsp_rdata} !== {exp_gnt[k], exp_dat[k]}) begin
        errors++; $display("FAIL rr_rsp%0d: got %b/%h exp %b/%h", k, rsp_valid, rsp_rdata, exp_gnt[k], exp_dat[k]);
      end
    end
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_ch1_only: got %b exp 10", req_ready); end
    step();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_wrap: got %b exp 01", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_hold: got %b exp 10", req_ready); end
    step();
    req_valid = '0;
    step();
  endtask

  task automatic test_back_to_back();
    req_valid = '0;
    drive(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    #1;
    step();
    drive(0, 1'b0, 32'h30, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready: got %b exp 01", req_ready); end
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h0}) begin errors++; $display("FAIL b2b_wack: got %b/%h exp 01/00000000", rsp_valid, rsp_rdata); end
    step();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 32'hCAFEF00D}) begin errors++; $display("FAIL b2b_raw: got %b/%h exp 01/cafef00d", rsp_valid, rsp_rdata); end
    step();
  endtask

  task automatic test_addr_range();
    logic rdy; logic [NCH-1:0] vld; logic [BW-1:0] data;
    xfer(0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, rdy, vld, data);
    xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rdy, vld, data);
    checks++; if ({vld, data} !== {2'b01, 32'h0}) begin errors++; $display("FAIL range_wack: got %b/%h exp 01/00000000", vld, data); end
`ifdef MEM_OOR_ERR_EN
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b exp 1", last_err); end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rdy, vld, data);
    checks++; if (data !== 32'h0BADCAFE) begin errors++; $display("FAIL oor_word0: got %h exp 0badcafe", data); end
    checks++; if (last_err !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b exp 0", last_err); end
`else
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rdy, vld, data);
    checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL wrap_word0: got %h exp 12345678", data); end
`endif
  endtask

  task automatic test_mid_reset();
    logic rdy; logic [NCH-1:0] vld; logic [BW-1:0] data;
    xfer(1, 1'b1, 32'h40, 32'h01020304, 4'hF, rdy, vld, data);
    drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    step();
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    drive(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mr_ready: got %b exp 00", req_ready); end
    step();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mr_drop: got %b exp 00", rsp_valid); end
    step();
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mr_quiet%0d: got %b exp 00", k, rsp_valid); end
    end
    drive(0, 1'b0, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mr_ptr: got %b exp 01", req_ready); end
    step();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h01020304}) begin errors++; $display("FAIL mr_nowrite: got %b/%h exp 01/01020304", rsp_valid, rsp_rdata); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_round_robin();
    test_back_to_back();
    test_addr_range();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
